// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - aluop encodings (OP_AND .. OP_REMU)
//   - control FSM state type alu_state_t
//   - opcode classification helpers
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_MULHU = 4'b1001;
   localparam logic [3:0] OP_DIVU  = 4'b1010;
   localparam logic [3:0] OP_REMU  = 4'b1011;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_t;

   // Opcodes that normally use the iterative datapath.
   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response channels of the multi-cycle ALU.
//   request : in_valid, in_ready, a, b, aluop
//   response: out_valid, out_ready, s, iszero
// master = requester/consumer side, slave = ALU side.
interface alu_mc_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       aluop;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             iszero;

   modport master (
      output in_valid, a, b, aluop, out_ready,
      input  in_ready, out_valid, s, iszero
   );

   modport slave (
      input  in_valid, a, b, aluop, out_ready,
      output in_ready, out_valid, s, iszero
   );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative unsigned multiply / restoring divide, one bit per cycle.
//   clk, rst_n      : clock, async active-low reset
//   start           : load operands and begin (is_div selects divide)
//   op_a, op_b      : operands, sampled on start
//   done            : high on the edge that performs the final iteration
//   res_lo, res_hi  : result after that edge (valid together with done)
//                     multiply: low/high product; divide: quotient/remainder
module mdu_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic               busy_q, busy_d;
   logic               div_q, div_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits shifting into quotient}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // Multiplicand or divisor.
   logic [WIDTH-1:0]   m_q, m_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;

   always_comb begin
      busy_d = busy_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      m_d    = m_q;
      done   = 1'b0;

      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_trial - {1'b0, m_q};

      if (start) begin
         busy_d = 1'b1;
         div_d  = is_div;
         cnt_d  = '0;
         m_d    = is_div ? op_b : op_a;
         acc_d  = {{WIDTH{1'b0}}, (is_div ? op_a : op_b)};
      end else if (busy_q) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (div_q) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (!div_diff[WIDTH]) begin
               acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         end
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            busy_d = 1'b0;
            done   = 1'b1;
         end
      end
   end

   // Result is taken from the next-state value so the caller can register it
   // on the same edge as the last iteration.
   assign res_lo = acc_d[WIDTH-1:0];
   assign res_hi = acc_d[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         m_q    <= '0;
      end else begin
         busy_q <= busy_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         m_q    <= m_d;
      end
   end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready request and response channels.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_mc_if slave (in_valid/in_ready/a/b/aluop request,
//                out_valid/out_ready/s/iszero response)
// Logic, add/sub, slt and divide-by-zero finish in one cycle; mul/mulhu and
// divu/remu run WIDTH iterations in mdu_iter. One operation in flight.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic     clk,
   input logic     rst_n,
   alu_mc_if.slave bus
);
   alu_state_t       state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             iszero_q, iszero_d;

   logic             b_zero;
   logic             mdu_start;
   logic             mdu_done;
   logic [WIDTH-1:0] mdu_lo;
   logic [WIDTH-1:0] mdu_hi;
   logic [WIDTH-1:0] single_res;
   logic             slt_bit;

   assign b_zero  = (bus.b == '0);
   assign slt_bit = ($signed(bus.a) < $signed(bus.b));

   // Single-cycle results; DIVU/REMU only reach this path when b is zero.
   always_comb begin
      single_res = '0;
      case (bus.aluop)
         OP_AND:  single_res = bus.a & bus.b;
         OP_OR:   single_res = bus.a | bus.b;
         OP_ADD:  single_res = bus.a + bus.b;
         OP_SUB:  single_res = bus.a - bus.b;
         OP_SLT:  single_res = WIDTH'(slt_bit);
         OP_NOR:  single_res = ~(bus.a | bus.b);
         OP_DIVU: single_res = '1;
         OP_REMU: single_res = bus.a;
         default: single_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      s_d       = s_q;
      mdu_start = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d = bus.aluop;
               if (is_iter_op(bus.aluop) && !(is_div_op(bus.aluop) && b_zero)) begin
                  mdu_start = 1'b1;
                  state_d   = is_div_op(bus.aluop) ? DIV : MUL;
               end else begin
                  s_d     = single_res;
                  state_d = DONE;
               end
            end
         end
         MUL, DIV: begin
            if (mdu_done) begin
               s_d     = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? mdu_lo : mdu_hi;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // s only changes together with its flag, so the flag tracks s_d.
      iszero_d = (s_d == '0);
   end

   mdu_iter #(
      .WIDTH(WIDTH)
   ) u_mdu (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mdu_start),
      .is_div(is_div_op(bus.aluop)),
      .op_a  (bus.a),
      .op_b  (bus.b),
      .done  (mdu_done),
      .res_lo(mdu_lo),
      .res_hi(mdu_hi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= OP_AND;
         s_q      <= '0;
         iszero_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         s_q      <= s_d;
         iszero_q <= iszero_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.s         = s_q;
   assign bus.iszero    = iszero_q;
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU that replaces the single-cycle bit-slice ALU in the execute stage. It keeps the existing 4-bit `aluop` encoding for logic, add/sub and set-less-than, and adds iterative multiply and unsigned divide/remainder. Operands enter through a valid/ready request channel. Results leave through a valid/ready response channel together with a registered zero flag. Only one operation is in flight at a time.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 2.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width (derived; do not override).

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `aluop` in 4: operation select.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `s` out WIDTH: result.
- `iszero` out 1: high when `s` is all zeros.

## Operation
- aluop codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed)
  - 1100 NOR
  - 1000 MUL (low WIDTH bits of the unsigned product)
  - 1001 MULHU (high WIDTH bits)
  - 1010 DIVU
  - 1011 REMU
- Any other code: `s`=0, `iszero`=1, single-cycle path.
- ADD and SUB wrap modulo 2^WIDTH; no overflow output.
- SLT is a true signed compare: result is 1 iff $signed(a) < $signed(b), correct even when a−b overflows. Upper bits of the result are zero.
- MUL/MULHU: shift-add over a 2·WIDTH accumulator, one bit of B per cycle, WIDTH iterations.
- DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH iterations.
- Divide by zero (b=0) produces quotient all-ones and remainder = a, via the single-cycle path with no iterations.
- `a`, `b` and `aluop` are captured on acceptance. Later input changes are ignored.
- FSM states:
  - IDLE → DONE on accept of a single-cycle op or divide-by-zero.
  - IDLE → MUL on accept of MUL/MULHU.
  - IDLE → DIV on accept of DIVU/REMU with b≠0.
  - MUL/DIV → DONE when the counter reaches WIDTH.
  - DONE → IDLE on `out_ready`.
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- `s` and `iszero` are registered and held stable while `out_valid` is high and `out_ready` is low.

## Timing
- Accept happens on the edge where `in_valid` and `in_ready` are both high.
- Single-cycle ops: `out_valid` rises on the first edge after accept (latency 1).
- MUL/DIV: `out_valid` rises WIDTH+1 edges after accept (33 for WIDTH=32).
- The result handshake completes on the edge where `out_valid` and `out_ready` are both high. `in_ready` rises on that same edge, so the next accept can happen at the earliest one edge later. Throughput is therefore at best 1 operation per 2 cycles.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `s`=0, `iszero`=1, counter 0, accumulators 0.
- Asserting `rst_n` low mid-iteration aborts the operation immediately. No result is emitted after release.
- Requests are not accepted while busy. `in_valid` may be held high and is accepted once the block returns to IDLE.

## Structure
- Package `alu_pkg` holds:
  - aluop localparams (`OP_AND` … `OP_REMU`)
  - state enum `alu_state_t` {IDLE, MUL, DIV, DONE}
  - helper `is_iter_op()`
- Sub-module `mdu_iter` holds the iterative multiply/divide datapath: accumulators, counter, `start`/`done` interface, parametrised by WIDTH.
- The top-level `alu_mc` holds the FSM, the single-cycle ops and the output registers.

## Test plan
All cases use WIDTH=32.
- SUB with a=5, b=7 → `s`=0xFFFFFFFE, `iszero`=0, `out_valid` one cycle after accept. ADD with a=0xFFFFFFFF, b=1 → `s`=0, `iszero`=1.
- SLT with a=0x80000000, b=0x00000001 → `s`=1 (overflow case). SLT with a=0x7FFFFFFF, b=0xFFFFFFFF → `s`=0.
- MUL with a=b=0xFFFFFFFF → `s`=0x00000001. MULHU with the same operands → 0xFFFFFFFE. `out_valid` exactly 33 edges after accept; `in_ready`=0 throughout.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU with b=0, a=9 → 0xFFFFFFFF with latency 1. REMU with b=0 → 9.
- Hold `out_ready`=0 for 5 cycles after a result → `s`, `iszero` and `out_valid` stay stable and no new accept occurs. Release it → handshake completes, and a back-to-back AND is accepted on the following edge.
- Pull `rst_n` low at cycle 10 of a MUL → outputs return to reset values immediately. After release, `out_valid` stays 0 until a new request is made.
